barrier_scroller: RTL and testbench
===================================

Name: barrier_scroller

Overview:
Consumer of the pausable barrier-rate enable pulse. Each accepted enable scrolls the barrier field one column left. Every SPACING steps it inserts a new barrier column at the right edge, with the gap row chosen by an LFSR. It drives the barrier layer of the LED-matrix renderer and emits a one-cycle pass pulse to the score logic whenever a barrier clears the bird column.

Parameters:
COLS, 16, matrix width in columns; column 0 is leftmost.
ROWS, 16, matrix height in rows; row 0 is top.
GAP, 4, height of the opening in each barrier (rows).
SPACING, 5, scroll steps between barrier insertions (>=1).
BIRD_COL, 3, column occupied by the bird (1..COLS-1).
LFSR_SEED, 8'hA5, LFSR value loaded at reset (must be non-zero).

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high; clock clk
pause  input  1  freezes all state while high
scroll_en  input  1  one-cycle step pulse from the barrier-rate divider
grid  output  COLS*ROWS  barrier map; bit c*ROWS+r = cell (column c, row r), 1 = barrier
pass_pulse  output  1  one-cycle pulse: a barrier has just left BIRD_COL
barrier_cnt  output  8  barriers inserted since reset, wraps 255->0

Behaviour:
- Reset values: grid all 0, pass_pulse 0, barrier_cnt 0, spacing counter 0, lfsr = LFSR_SEED. Reset has priority over every other input.
- Step condition: step = scroll_en & ~pause & ~reset.
  - scroll_en while pause is high is dropped, not queued.
  - The pulse width is not checked. Every high cycle counts as a step.
- On a step edge, grid updates are visible the next cycle:
  - col[c] <= col[c+1] for c = 0..COLS-2.
  - Old col[0] is discarded.
  - col[COLS-1] <= new barrier column if spacing counter == 0, else all 0.
- Spacing counter, on a step:
  - If it is 0: insert, then reload with SPACING-1.
  - Otherwise: decrement.
  - The first step after reset therefore always inserts. Later inserts occur every SPACING steps.
- Gap selection:
  - g = lfsr[3:0]. If g > ROWS-GAP, gap_top = g - GAP; otherwise gap_top = g.
  - Barrier column = 1 in every row except rows gap_top..gap_top+GAP-1, which are 0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Update: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances only on steps that insert, after its current value has been used.
  - Never reaches 0 from a non-zero seed.
- barrier_cnt increments on every inserting step.
- pass_pulse:
  - Registered. High for exactly the one cycle after a step in which old col[BIRD_COL] was non-zero.
  - Low in every other cycle, including all paused cycles.
- Pause: grid, counters and lfsr hold. pass_pulse is forced 0 while pause is high.
- Reset mid-game: the next cycle matches post-reset state exactly, and the barrier sequence restarts from LFSR_SEED.
- Latency: a barrier inserted at step k occupies column COLS-1-j after step k+j. It leaves BIRD_COL on step k+COLS-BIRD_COL, giving pass_pulse on the following cycle.

Test Plan:
- Reset held 3 cycles, then idle 10 cycles with scroll_en=0 -> grid=0, pass_pulse=0, barrier_cnt=0 throughout.
- First step after reset (seed A5) -> col15 = 1 except rows 5..8 = 0; col0..14 = 0; barrier_cnt=1; lfsr=8'h4A.
- Steps 2..6 -> col11 holds the first barrier after step 5. Step 6 inserts a second barrier in col15 (g=10, gap rows 10..13), col10 holds the first, barrier_cnt=2.
- 13 steps after the first insertion the barrier sits in col3. Step 14 -> pass_pulse high exactly one cycle after that step edge, first barrier now in col2.
- pause=1 with 5 scroll_en pulses, then pause=0 -> grid, barrier_cnt and lfsr unchanged, no pass_pulse. The next step proceeds exactly as if no pause had occurred.
- Reset asserted with scroll_en=1 in the same cycle mid-game -> no shift; all state at reset values. The following step reproduces the step-2 scenario's column (gap rows 5..8).

Source files
------------

// File: rtl/barrier_scroller.sv
// Scrolls the barrier field one column left per accepted step and inserts an
// LFSR-gapped barrier column at the right edge every SPACING steps.
module barrier_scroller #(
    parameter int          COLS      = 16,
    parameter int          ROWS      = 16,
    parameter int          GAP       = 4,
    parameter int          SPACING   = 5,
    parameter int          BIRD_COL  = 3,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pause,
    input  logic                 scroll_en,
    output logic [COLS*ROWS-1:0] grid,
    output logic                 pass_pulse,
    output logic [7:0]           barrier_cnt
);

    localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;

    logic [COLS*ROWS-1:0] grid_q;
    logic [COLS*ROWS-1:0] grid_next;
    logic [7:0]           lfsr;
    logic [SW-1:0]        space_cnt;
    logic [7:0]           cnt_q;
    logic                 pass_q;
    logic                 step;
    logic                 insert;
    logic                 old_bird;
    logic [3:0]           g;
    logic [7:0]           gap_top;
    logic [ROWS-1:0]      new_col;

    assign step     = scroll_en & ~pause & ~reset;
    assign insert   = step & (space_cnt == '0);
    assign old_bird = |grid_q[BIRD_COL*ROWS +: ROWS];
    assign g        = lfsr[3:0];

    // Gap positions that would run off the bottom are pulled up by GAP rows.
    always_comb begin
        gap_top = {4'd0, g};
        if (int'(g) > ROWS - GAP)
            gap_top = {4'd0, g} - 8'(GAP);
        new_col = '0;
        for (int r = 0; r < ROWS; r++)
            new_col[r] = ~((r >= int'(gap_top)) && (r < int'(gap_top) + GAP));
    end

    // Column c lives at bits c*ROWS.., so a left scroll is a right shift by ROWS.
    always_comb begin
        grid_next = {(insert ? new_col : {ROWS{1'b0}}), grid_q[COLS*ROWS-1:ROWS]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q    <= '0;
            lfsr      <= LFSR_SEED;
            space_cnt <= '0;
            cnt_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            pass_q <= step & old_bird;
            if (step) begin
                grid_q <= grid_next;
                if (insert) begin
                    space_cnt <= SW'(SPACING - 1);
                    lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    cnt_q     <= cnt_q + 8'd1;
                end else begin
                    space_cnt <= space_cnt - SW'(1);
                end
            end
        end
    end

    assign grid        = grid_q;
    assign pass_pulse  = pass_q & ~pause;
    assign barrier_cnt = cnt_q;

endmodule

// File: tb/tb_barrier_scroller.sv
// Directed vector bench for barrier_scroller: one table row per clock cycle,
// followed by a long run that reaches the wrapped-gap case.
module tb_barrier_scroller;

    logic         clk = 1'b0;
    logic         reset;
    logic         pause;
    logic         scroll_en;
    logic [255:0] grid;
    logic         pass_pulse;
    logic [7:0]   barrier_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    barrier_scroller dut (
        .clk         (clk),
        .reset       (reset),
        .pause       (pause),
        .scroll_en   (scroll_en),
        .grid        (grid),
        .pass_pulse  (pass_pulse),
        .barrier_cnt (barrier_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic pse;
        logic en;
        int   n;     // accepted steps since reset, after this cycle's edge
        logic pass;
    } vec_t;

    vec_t vecs[$];

    // LFSR values in insertion order from seed A5 (hand-derived).
    logic [7:0] lfsr_seq [0:9] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54,
                                   8'hA9, 8'h53, 8'hA7, 8'h4E, 8'h9D};

    localparam logic [15:0] GAP5  = 16'hFE1F;  // open rows 5..8
    localparam logic [15:0] GAP10 = 16'hC3FF;  // open rows 10..13
    localparam logic [15:0] GAP7  = 16'hF87F;  // open rows 7..10

    function automatic logic [255:0] place(int c, logic [15:0] v);
        logic [255:0] t;
        t = 256'(v);
        return t << (c * 16);
    endfunction

    // Barriers A,B,C,D inserted at steps 1,6,11,16 sit in col 16+5i-n.
    function automatic logic [255:0] exp_grid(int n);
        logic [255:0] e;
        e = '0;
        if (n >= 1  && n <= 16) e |= place(16 - n, GAP5);
        if (n >= 6  && n <= 21) e |= place(21 - n, GAP10);
        if (n >= 11 && n <= 26) e |= place(26 - n, GAP5);
        if (n >= 16 && n <= 31) e |= place(31 - n, GAP10);
        return e;
    endfunction

    task automatic check(string name, int idx, logic [255:0] got, logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic add(logic rst, logic pse, logic en, int n, logic pass);
        vec_t v;
        v.rst = rst; v.pse = pse; v.en = en; v.n = n; v.pass = pass;
        vecs.push_back(v);
    endtask

    initial begin
        int cnt;
        reset = 1'b1; pause = 1'b0; scroll_en = 1'b0;

        // Reset held 3 cycles (one with scroll_en high), then 10 idle cycles.
        add(1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0);
        // Steps 1..14; the first barrier leaves the bird column on step 14.
        for (int s = 1; s <= 14; s++) add(0, 0, 1, s, s == 14);
        add(0, 0, 0, 14, 0);
        // Paused scroll pulses are dropped.
        for (int i = 0; i < 5; i++) add(0, 1, 1, 14, 0);
        add(0, 1, 0, 14, 0);
        // Resume: steps 15..20, second barrier passes on step 19.
        for (int s = 15; s <= 20; s++) add(0, 0, 1, s, s == 19);
        add(0, 0, 0, 20, 0);
        // Mid-game reset with scroll_en high, then the sequence restarts.
        add(1, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst;
            pause     = vecs[i].pse;
            scroll_en = vecs[i].en;
            @(posedge clk);
            #1;
            cnt = (vecs[i].n + 4) / 5;
            check("grid", i, grid, exp_grid(vecs[i].n));
            check("pass_pulse", i, 256'(pass_pulse), 256'(vecs[i].pass));
            check("barrier_cnt", i, 256'(barrier_cnt), 256'(cnt));
            check("lfsr", i, 256'(dut.lfsr), 256'(lfsr_seq[cnt]));
        end

        // Long run to the ninth insertion (lfsr 4E, g=14 > 12 -> gap rows 10..13).
        reset = 1'b1; pause = 1'b0; scroll_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; scroll_en = 1'b1;
        for (int s = 0; s < 41; s++) begin
            @(posedge clk); #1;
        end
        scroll_en = 1'b0;
        check("long col15", 0, 256'(grid[255:240]), 256'(GAP10));
        check("long col10", 0, 256'(grid[175:160]), 256'(GAP7));
        check("long cnt", 0, 256'(barrier_cnt), 256'(9));
        check("long lfsr", 0, 256'(dut.lfsr), 256'(lfsr_seq[9]));

        // A pass pulse present on the output is masked while pause is high.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; scroll_en = 1'b1;
        for (int s = 0; s < 14; s++) begin
            @(posedge clk); #1;
        end
        scroll_en = 1'b0;
        check("pass before mask", 0, 256'(pass_pulse), 256'(1));
        pause = 1'b1;
        #1;
        check("pass masked", 0, 256'(pass_pulse), 256'(0));
        pause = 1'b0;
        @(posedge clk); #1;
        check("pass cleared", 0, 256'(pass_pulse), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
